// File: rtl/multi_port_arbiter_pkg.sv
// Shared types for the multi-port cacheline arbiter: FSM state and operation encoding.
package multi_port_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } arb_op_t;

    // A port raising both read and write is treated as a write.
    function automatic arb_op_t sel_op(input logic rd, input logic wr);
        if (wr) return OP_WRITE;
        if (rd) return OP_READ;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/multi_port_arbiter_if.sv
// Bundle of requester-side ports and cacheline-adaptor signals around the arbiter.
interface multi_port_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic [NUM_PORTS-1:0]                 req_read;
    logic [NUM_PORTS-1:0]                 req_write;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]                 req_resp;
    logic [LINE_WIDTH-1:0]                req_rdata;
    logic                                 mem_read;
    logic                                 mem_write;
    logic [ADDR_WIDTH-1:0]                mem_address;
    logic [LINE_WIDTH-1:0]                mem_wdata;
    logic [LINE_WIDTH-1:0]                mem_rdata;
    logic                                 mem_resp;

    modport slave (
        input  req_read, req_write, req_address, req_wdata, mem_rdata, mem_resp,
        output req_resp, req_rdata, mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output req_read, req_write, req_address, req_wdata, mem_rdata, mem_resp,
        input  req_resp, req_rdata, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/multi_port_arbiter_pick.sv
// Combinational winner select: first requesting port found scanning upward from ptr, wrapping.
module arb_pick #(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [$clog2(NUM_PORTS)-1:0] ptr,
    output logic [NUM_PORTS-1:0]         gnt,
    output logic                         vld
);
    localparam int PTR_W = $clog2(NUM_PORTS);

    logic [PTR_W:0] idx;
    logic           found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_PORTS))
                idx = idx - (PTR_W+1)'(NUM_PORTS);
            if (!found && req[idx[PTR_W-1:0]]) begin
                gnt[idx[PTR_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
    end

    assign vld = found;

endmodule

// File: rtl/multi_port_arbiter.sv
// Serialises NUM_PORTS cache ports onto one cacheline adaptor, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority.
module multi_port_arbiter
    import multi_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input logic                 clk,
    input logic                 reset_n,
    multi_port_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_PORTS);

    arb_state_t            state, state_next;
    logic [PTR_W-1:0]      gnt_idx, gnt_idx_next;
    logic                  mem_read_q, mem_read_next;
    logic                  mem_write_q, mem_write_next;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_next;
    logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_next;
    logic [NUM_PORTS-1:0]  req_any, pick_gnt, resp;
    logic                  pick_vld;
    logic [PTR_W-1:0]      ptr, pick_idx;
    arb_op_t               pick_op;

    assign req_any = bus.req_read | bus.req_write;

    arb_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .req (req_any),
        .ptr (ptr),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (pick_gnt[i]) pick_idx = PTR_W'(i);
    end

    assign pick_op = sel_op(bus.req_read[pick_idx], bus.req_write[pick_idx]);

`ifdef ARB_ROUND_ROBIN_EN
    // ptr holds where the next search starts: one past the most recent winner.
    logic [PTR_W-1:0] ptr_next;
    assign ptr_next = (pick_idx == PTR_W'(NUM_PORTS-1)) ? '0 : pick_idx + PTR_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else if (state == IDLE && pick_vld)
            ptr <= ptr_next;
    end
`else
    assign ptr = '0;
`endif

    always_comb begin
        state_next       = state;
        gnt_idx_next     = gnt_idx;
        mem_read_next    = mem_read_q;
        mem_write_next   = mem_write_q;
        mem_address_next = mem_address_q;
        mem_wdata_next   = mem_wdata_q;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_next       = BUSY;
                    gnt_idx_next     = pick_idx;
                    mem_read_next    = (pick_op == OP_READ);
                    mem_write_next   = (pick_op == OP_WRITE);
                    mem_address_next = bus.req_address[pick_idx];
                    mem_wdata_next   = bus.req_wdata[pick_idx];
                end
            end
            BUSY: begin
                // Address and data stay latched; only the strobes drop on completion.
                if (bus.mem_resp) begin
                    state_next     = IDLE;
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        resp = '0;
        if (state == BUSY && bus.mem_resp)
            resp[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            gnt_idx       <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state         <= state_next;
            gnt_idx       <= gnt_idx_next;
            mem_read_q    <= mem_read_next;
            mem_write_q   <= mem_write_next;
            mem_address_q <= mem_address_next;
            mem_wdata_q   <= mem_wdata_next;
        end
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.req_resp    = resp;
    assign bus.req_rdata   = bus.mem_rdata;

endmodule
